// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller: decodes ALUOp/funct into an EX-stage operation code,
// stalls the front end while a multi-cycle multiply occupies EX, and supports flush.
module alu_ctrl_seq #(
  parameter int CTRL_W   = 4,
  parameter int MUL_LAT  = 4,
  parameter int NOP_CODE = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [5:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              valid_o,
  output logic              illegal_o,
  output logic              stall_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CTRL_W-1:0] NOP      = CTRL_W'(NOP_CODE);
  localparam logic [CTRL_W-1:0] MUL_CODE = CTRL_W'(3);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;

  logic [3:0] dec_code;
  logic       dec_illegal;
  logic       dec_mul;
  logic       accept;

  always_comb begin
    dec_code    = 4'd0;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    case (ALUOp_i)
      3'b000: begin
        case (funct_i)
          6'd32:   dec_code = 4'd2;
          6'd34:   dec_code = 4'd6;
          6'd36:   dec_code = 4'd0;
          6'd37:   dec_code = 4'd1;
          6'd42:   dec_code = 4'd7;
          6'd24: begin
            dec_code = 4'd3;
            dec_mul  = 1'b1;
          end
          6'd0:    dec_code = 4'd8;
          6'd2:    dec_code = 4'd9;
          default: dec_illegal = 1'b1;
        endcase
      end
      3'b001:  dec_code = 4'd2;
      3'b010:  dec_code = 4'd7;
      3'b011:  dec_code = 4'd6;
      3'b100:  dec_code = 4'd1;
      3'b101:  dec_code = 4'd0;
      3'b110:  dec_code = 4'd10;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign stall_o = (state_q == S_MUL);
  assign accept  = valid_i & ~stall_o & ~flush_i;

  // Flush overrides everything; otherwise IDLE issues or enters MUL, MUL counts down.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ctrl_d  = NOP;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (dec_illegal) begin
              ctrl_d    = NOP;
              valid_d   = 1'b1;
              illegal_d = 1'b1;
            end else if (dec_mul && (MUL_LAT > 1)) begin
              ctrl_d  = MUL_CODE;
              cnt_d   = CNT_LOAD;
              state_d = S_MUL;
            end else begin
              ctrl_d  = CTRL_W'(dec_code);
              valid_d = 1'b1;
            end
          end
        end
        S_MUL: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= NOP;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUCtrl_o = ctrl_q;
  assign valid_o   = valid_q;
  assign illegal_o = illegal_q;

endmodule
